// File: rtl/ipsl_pcie_dma_rx_mwr_wr_ctrl.sv
// Writes memory-write TLP payload beats into the BAR RAM with per-byte enables.
// Optional running DW counter (o_wr_dw_cnt) enabled by `define PCIE_DMA_MWR_DW_CNT_EN.
module ipsl_pcie_dma_rx_mwr_wr_ctrl #(
  parameter int unsigned ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_wr_start,
  input  logic [9:0]            i_wr_length,
  input  logic [63:0]           i_wr_addr,
  input  logic [3:0]            i_first_be,
  input  logic [3:0]            i_last_be,
  input  logic                  i_wr_data_vld,
  input  logic [127:0]          i_wr_data,
  input  logic                  i_wr_data_last,
  input  logic                  i_rx_restart,
  output logic                  o_wr_busy,
  output logic                  o_wr_done,
  output logic                  o_len_err,
  output logic                  o_bar_wr_en,
  output logic [ADDR_WIDTH-1:0] o_bar_wr_addr,
  output logic [127:0]          o_bar_wr_data,
  output logic [15:0]           o_bar_wr_byte_en
`ifdef PCIE_DMA_MWR_DW_CNT_EN
  ,
  output logic [31:0]           o_wr_dw_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_WR, S_DONE, S_DROP} state_t;

  state_t                  state_q;
  logic [10:0]             len_q;
  logic [1:0]              off_q;
  logic [ADDR_WIDTH-1:0]   waddr_q;
  logic [3:0]              fbe_q, lbe_q;
  logic [8:0]              exp_q, cnt_q;
  logic                    wr_en_q, done_q, err_q;
  logic [ADDR_WIDTH-1:0]   wr_addr_q;
  logic [127:0]            wr_data_q;
  logic [15:0]             be_q;

  logic [10:0]             start_len_d;
  logic [8:0]              start_exp_d;
  logic [15:0]             be_d;
  logic [11:0]             pos, rel;
  logic [3:0]              lane_be;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_wr_addr[63:ADDR_WIDTH+4], i_wr_addr[1:0]};

  always_comb begin
    start_len_d = (i_wr_length == 10'd0) ? 11'd1024 : {1'b0, i_wr_length};
    start_exp_d = 9'((12'(start_len_d) + 12'(i_wr_addr[3:2]) + 12'd3) >> 2);
  end

  // Lane position relative to the first payload DW: p = 4*beat + lane - off.
  always_comb begin
    be_d    = '0;
    pos     = '0;
    rel     = '0;
    lane_be = '0;
    for (int unsigned n = 0; n < 4; n++) begin
      pos = {1'b0, cnt_q, 2'b00} + 12'(n);
      rel = pos - {10'b0, off_q};
      if (pos >= {10'b0, off_q} && rel < {1'b0, len_q}) begin
        if (rel == 12'd0)                     lane_be = fbe_q;
        else if (rel == {1'b0, len_q} - 12'd1) lane_be = lbe_q;
        else                                  lane_be = 4'hF;
        be_d[4*n +: 4] = lane_be;
      end
    end
  end

`ifdef PCIE_DMA_MWR_DW_CNT_EN
  logic [2:0]  lanes_d;
  logic [31:0] dw_cnt_q;
  always_comb begin
    lanes_d = '0;
    for (int unsigned n = 0; n < 4; n++)
      if (|be_d[4*n +: 4]) lanes_d = lanes_d + 3'd1;
  end
  assign o_wr_dw_cnt = dw_cnt_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      off_q     <= '0;
      waddr_q   <= '0;
      fbe_q     <= '0;
      lbe_q     <= '0;
      exp_q     <= '0;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      be_q      <= '0;
`ifdef PCIE_DMA_MWR_DW_CNT_EN
      dw_cnt_q  <= '0;
`endif
    end else begin
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      if (i_rx_restart) begin
        state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: if (i_wr_start) begin
            len_q   <= start_len_d;
            off_q   <= i_wr_addr[3:2];
            waddr_q <= i_wr_addr[ADDR_WIDTH+3:4];
            fbe_q   <= i_first_be;
            lbe_q   <= i_last_be;
            exp_q   <= start_exp_d;
            cnt_q   <= '0;
            state_q <= S_WR;
          end
          S_WR: if (i_wr_data_vld && cnt_q < exp_q) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= waddr_q;
            wr_data_q <= i_wr_data;
            be_q      <= be_d;
            waddr_q   <= waddr_q + ADDR_WIDTH'(1);
            cnt_q     <= cnt_q + 9'd1;
`ifdef PCIE_DMA_MWR_DW_CNT_EN
            dw_cnt_q  <= dw_cnt_q + 32'(lanes_d);
`endif
            if (cnt_q == exp_q - 9'd1) begin
              if (i_wr_data_last) begin
                state_q <= S_DONE;
              end else begin
                err_q   <= 1'b1;
                state_q <= S_DROP;
              end
            end else if (i_wr_data_last) begin
              err_q   <= 1'b1;
              state_q <= S_DONE;
            end
          end
          S_DROP: if (i_wr_data_vld && i_wr_data_last) state_q <= S_DONE;
          S_DONE: begin
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign o_wr_busy        = (state_q != S_IDLE);
  assign o_wr_done        = done_q;
  assign o_len_err        = err_q;
  assign o_bar_wr_en      = wr_en_q;
  assign o_bar_wr_addr    = wr_addr_q;
  assign o_bar_wr_data    = wr_data_q;
  assign o_bar_wr_byte_en = be_q;

endmodule

// File: tb/tb_ipsl_pcie_dma_rx_mwr_wr_ctrl.sv
// Randomized bench for ipsl_pcie_dma_rx_mwr_wr_ctrl against a per-cycle expected-output schedule
// built from a byte-level model of each TLP.
module tb_ipsl_pcie_dma_rx_mwr_wr_ctrl;
  localparam int unsigned AW = 9;
  localparam int MAXC = 40000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_wr_start;
  logic [9:0]    i_wr_length;
  logic [63:0]   i_wr_addr;
  logic [3:0]    i_first_be, i_last_be;
  logic          i_wr_data_vld;
  logic [127:0]  i_wr_data;
  logic          i_wr_data_last;
  logic          i_rx_restart;
  logic          o_wr_busy, o_wr_done, o_len_err, o_bar_wr_en;
  logic [AW-1:0] o_bar_wr_addr;
  logic [127:0]  o_bar_wr_data;
  logic [15:0]   o_bar_wr_byte_en;
`ifdef PCIE_DMA_MWR_DW_CNT_EN
  logic [31:0]   o_wr_dw_cnt;
`endif

  always #5 clk = ~clk;

  ipsl_pcie_dma_rx_mwr_wr_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_wr_start       (i_wr_start),
    .i_wr_length      (i_wr_length),
    .i_wr_addr        (i_wr_addr),
    .i_first_be       (i_first_be),
    .i_last_be        (i_last_be),
    .i_wr_data_vld    (i_wr_data_vld),
    .i_wr_data        (i_wr_data),
    .i_wr_data_last   (i_wr_data_last),
    .i_rx_restart     (i_rx_restart),
    .o_wr_busy        (o_wr_busy),
    .o_wr_done        (o_wr_done),
    .o_len_err        (o_len_err),
    .o_bar_wr_en      (o_bar_wr_en),
    .o_bar_wr_addr    (o_bar_wr_addr),
    .o_bar_wr_data    (o_bar_wr_data),
    .o_bar_wr_byte_en (o_bar_wr_byte_en)
`ifdef PCIE_DMA_MWR_DW_CNT_EN
    ,
    .o_wr_dw_cnt      (o_wr_dw_cnt)
`endif
  );

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;
  int          cyc = 0;

  // Expected outputs indexed by cycle number; default is all-quiet.
  bit            e_en   [MAXC];
  logic [AW-1:0] e_addr [MAXC];
  logic [127:0]  e_data [MAXC];
  logic [15:0]   e_be   [MAXC];
  bit            e_done [MAXC];
  bit            e_err  [MAXC];
  bit            e_busy [MAXC];
  longint unsigned e_dw = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Number of 16-byte RAM words touched by the payload.
  function automatic int n_beats(input logic [63:0] addr, input int len);
    int fb;
    fb = int'(addr[3:0]) & 12;
    return (fb + 4 * len - 1) / 16 + 1;
  endfunction

  // Byte-level view: byte b of word k holds payload byte r = 16k + b - first_byte.
  function automatic logic [15:0] model_be(input logic [63:0] addr, input int len,
                                           input logic [3:0] fbe, input logic [3:0] lbe, input int k);
    logic [15:0] be;
    logic [3:0]  dwbe;
    int fb, r, d;
    be = '0;
    fb = int'(addr[3:0]) & 12;
    for (int b = 0; b < 16; b++) begin
      r = 16 * k + b - fb;
      if (r >= 0 && r / 4 < len) begin
        d    = r / 4;
        dwbe = (d == 0) ? fbe : (d == len - 1) ? lbe : 4'hF;
        be[b] = dwbe[r % 4];
      end
    end
    return be;
  endfunction

  task automatic idle_inputs();
    i_wr_start     = 1'b0;
    i_wr_data_vld  = 1'b0;
    i_wr_data_last = 1'b0;
    i_rx_restart   = 1'b0;
    i_wr_length    = 10'($urandom);
    i_wr_addr      = {$urandom, $urandom};
    i_first_be     = 4'($urandom);
    i_last_be      = 4'($urandom);
    i_wr_data      = rnd128();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    check("wr_en", 128'(o_bar_wr_en), 128'(e_en[cyc]));
    if (e_en[cyc]) begin
      check("wr_addr", 128'(o_bar_wr_addr), 128'(e_addr[cyc]));
      check("wr_data", o_bar_wr_data, e_data[cyc]);
      check("byte_en", 128'(o_bar_wr_byte_en), 128'(e_be[cyc]));
    end
    check("wr_done", 128'(o_wr_done), 128'(e_done[cyc]));
    check("len_err", 128'(o_len_err), 128'(e_err[cyc]));
    check("wr_busy", 128'(o_wr_busy), 128'(e_busy[cyc]));
`ifdef PCIE_DMA_MWR_DW_CNT_EN
    check("dw_cnt", 128'(o_wr_dw_cnt), 128'(e_dw[31:0]));
`endif
    idle_inputs();
  endtask

  task automatic expect_write(input int c, input logic [AW-1:0] a, input logic [127:0] d, input logic [15:0] be);
    e_en[c]   = 1'b1;
    e_addr[c] = a;
    e_data[c] = d;
    e_be[c]   = be;
    for (int n = 0; n < 4; n++)
      if (|be[4*n +: 4]) e_dw++;
  endtask

  // Stall cycles inside a transfer: start and un-qualified last must be ignored.
  task automatic gap();
    repeat ($urandom_range(0, 2)) begin
      if ($urandom_range(0, 3) == 0) i_wr_start = 1'b1;
      i_wr_data_last = 1'($urandom);
      e_busy[cyc+1] = 1'b1;
      step();
    end
  endtask

  // Idle cycles with stray beats that must be ignored.
  task automatic idle_cycles(input int n);
    repeat (n) begin
      i_wr_data_vld  = 1'($urandom);
      i_wr_data_last = 1'($urandom);
      step();
    end
  endtask

  // mode 0: normal; 1: early last on beat j; 2: missing last then j dropped beats; 3: restart on beat j
  task automatic run_tlp(input logic [63:0] addr, input int len, input logic [3:0] fbe,
                         input logic [3:0] lbe, input int mode, input int j, input bit gaps);
    int nb, last_k;
    logic [AW-1:0] wbase;
    logic [127:0]  d;
    nb    = n_beats(addr, len);
    wbase = AW'(addr >> 4);
    i_wr_start  = 1'b1;
    i_wr_length = 10'(len);
    i_wr_addr   = addr;
    i_first_be  = fbe;
    i_last_be   = lbe;
    e_busy[cyc+1] = 1'b1;
    step();
    last_k = (mode == 1) ? j : nb - 1;
    for (int k = 0; k <= last_k; k++) begin
      if (gaps) gap();
      d = rnd128();
      i_wr_data     = d;
      i_wr_data_vld = 1'b1;
      if (mode == 3 && k == j) begin
        i_rx_restart   = 1'b1;
        i_wr_data_last = 1'($urandom);
        step();
        return;
      end
      i_wr_data_last = (k == last_k) && (mode != 2);
      expect_write(cyc + 1, wbase + AW'(k), d, model_be(addr, len, fbe, lbe, k));
      if (k == last_k && mode != 0) e_err[cyc+1] = 1'b1;
      e_busy[cyc+1] = 1'b1;
      step();
    end
    if (mode == 2) begin
      for (int k = 0; k < j; k++) begin
        if (gaps) gap();
        i_wr_data_vld  = 1'b1;
        i_wr_data_last = (k == j - 1);
        e_busy[cyc+1]  = 1'b1;
        step();
      end
    end
    if ($urandom_range(0, 3) == 0) i_wr_start = 1'b1;
    e_done[cyc+1] = 1'b1;
    step();
  endtask

  initial begin
    int len, nb, mode, j, r;
    logic [63:0] addr;
    rst_n = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 128'(o_wr_busy), 128'(0));
    check("rst_done", 128'(o_wr_done), 128'(0));
    check("rst_err", 128'(o_len_err), 128'(0));
    check("rst_wr_en", 128'(o_bar_wr_en), 128'(0));
    check("rst_addr", 128'(o_bar_wr_addr), 128'(0));
    check("rst_data", o_bar_wr_data, 128'(0));
    check("rst_be", 128'(o_bar_wr_byte_en), 128'(0));
    rst_n = 1'b1;
    idle_cycles(2);

    run_tlp(64'h1000, 8, 4'hF, 4'hF, 0, 0, 1'b0);
    idle_cycles(1);
    run_tlp(64'h000C, 2, 4'hE, 4'h3, 0, 0, 1'b0);
    run_tlp(64'h0008, 1, 4'h6, 4'hA, 0, 0, 1'b0);
    run_tlp(64'h1FF0, 8, 4'hF, 4'hF, 0, 0, 1'b0);
    run_tlp(64'h0000, 8, 4'hF, 4'hF, 1, 0, 1'b0);
    run_tlp(64'h0040, 4, 4'hF, 4'hF, 2, 2, 1'b0);
    run_tlp(64'h0000, 16, 4'hF, 4'hF, 3, 1, 1'b0);
    run_tlp(64'h2000, 4, 4'h1, 4'h8, 0, 0, 1'b0);
    run_tlp(64'h3004, 1024, 4'hC, 4'h7, 0, 0, 1'b0);
    // start and restart together: start is dropped
    i_wr_start   = 1'b1;
    i_rx_restart = 1'b1;
    step();
    idle_cycles(3);

    for (int t = 0; t < 150 && cyc < MAXC - 1200; t++) begin
      r    = $urandom_range(0, 19);
      len  = (r == 0) ? 1024 : (r < 4) ? $urandom_range(17, 200) : $urandom_range(1, 16);
      addr = {$urandom, $urandom};
      nb   = n_beats(addr, len);
      mode = $urandom_range(0, 3);
      if (mode == 1 && nb < 2) mode = 0;
      j = (mode == 1) ? $urandom_range(0, nb - 2) :
          (mode == 2) ? $urandom_range(1, 3) :
          (mode == 3) ? $urandom_range(0, nb - 1) : 0;
      run_tlp(addr, len, 4'($urandom), 4'($urandom), mode, j, 1'($urandom));
      idle_cycles($urandom_range(0, 2));
    end
    idle_cycles(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
